// File: rtl/word_decision_if.sv
// Score-frame stream into word_decision: one frame of NUM_CLASSES signed scores
// per valid/ready handshake.
interface word_decision_if #(
  parameter int NUM_CLASSES = 8,
  parameter int DATA_W      = 16
);
  logic                          prob_valid;
  logic                          prob_ready;
  logic [NUM_CLASSES*DATA_W-1:0] prob_flat;

  modport master (output prob_valid, output prob_flat, input prob_ready);
  modport slave  (input prob_valid, input prob_flat, output prob_ready);
endinterface

// File: rtl/word_decision.sv
// Final speech-recognition stage: sequential argmax over the class scores of a frame,
// then emits a word once one class wins HOLD_FRAMES consecutive above-threshold frames.
module word_decision #(
  parameter int NUM_CLASSES = 8,
  parameter int DATA_W      = 16,
  parameter int THRESH      = 256,
  parameter int HOLD_FRAMES = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  word_decision_if.slave             prob,
  output logic                       frame_done,
  output logic [$clog2(NUM_CLASSES)-1:0] frame_id,
  output logic signed [DATA_W-1:0]   frame_score,
  output logic                       word_valid,
  output logic [$clog2(NUM_CLASSES)-1:0] word_id,
  output logic signed [DATA_W-1:0]   word_score,
  output logic [15:0]                frames_seen
);

  localparam int ID_W  = $clog2(NUM_CLASSES);
  localparam int RUN_W = $clog2(HOLD_FRAMES + 1);
  localparam logic signed [DATA_W-1:0] THRESH_S = DATA_W'(THRESH);
  localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NUM_CLASSES - 1);
  localparam logic [RUN_W-1:0] HOLD_R   = RUN_W'(HOLD_FRAMES);
  localparam logic [RUN_W-1:0] HOLD_M1  = RUN_W'(HOLD_FRAMES - 1);
  localparam bit               HOLD_ONE = (HOLD_FRAMES == 1);

  typedef enum logic [1:0] {IDLE, SCAN, DECIDE} state_t;

  state_t                    state;
  logic signed [DATA_W-1:0]  scores [NUM_CLASSES];
  logic signed [DATA_W-1:0]  best;
  logic [ID_W-1:0]           best_id;
  logic [ID_W-1:0]           idx;
  logic [ID_W-1:0]           cand;
  logic [RUN_W-1:0]          run;

  assign prob.prob_ready = (state == IDLE) && rst_n;

  // Frame capture, one-class-per-cycle argmax, then run-length decision on the winner.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      best        <= '0;
      best_id     <= '0;
      idx         <= '0;
      cand        <= '0;
      run         <= '0;
      frame_done  <= 1'b0;
      frame_id    <= '0;
      frame_score <= '0;
      word_valid  <= 1'b0;
      word_id     <= '0;
      word_score  <= '0;
      frames_seen <= '0;
    end else begin
      frame_done <= 1'b0;
      word_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (prob.prob_valid) begin
            for (int k = 0; k < NUM_CLASSES; k++) begin
              scores[k] <= prob.prob_flat[k*DATA_W +: DATA_W];
            end
            best        <= $signed(prob.prob_flat[DATA_W-1:0]);
            best_id     <= '0;
            idx         <= ID_W'(1);
            frames_seen <= frames_seen + 16'd1;
            state       <= SCAN;
          end
        end
        SCAN: begin
          // Strict compare so ties keep the lower index.
          if (scores[idx] > best) begin
            best    <= scores[idx];
            best_id <= idx;
          end
          if (idx == LAST_ID) begin
            state <= DECIDE;
          end
          idx <= idx + 1'b1;
        end
        DECIDE: begin
          frame_done  <= 1'b1;
          frame_id    <= best_id;
          frame_score <= best;
          if (best < THRESH_S) begin
            run <= '0;
          end else if (best_id == cand && run != '0) begin
            // Saturated runs hold at HOLD_FRAMES and never re-emit.
            if (run != HOLD_R) begin
              run <= run + 1'b1;
            end
            if (run == HOLD_M1) begin
              word_valid <= 1'b1;
              word_id    <= best_id;
              word_score <= best;
            end
          end else begin
            cand <= best_id;
            run  <= RUN_W'(1);
            if (HOLD_ONE) begin
              word_valid <= 1'b1;
              word_id    <= best_id;
              word_score <= best;
            end
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_word_decision.sv
// Directed bench for word_decision: frame timing, argmax, tie/negative handling,
// hold-run word emission and mid-scan reset.
module tb_word_decision;

  logic        clk;
  logic        rst_n;
  logic        frame_done;
  logic [2:0]  frame_id;
  logic signed [15:0] frame_score;
  logic        word_valid;
  logic [2:0]  word_id;
  logic signed [15:0] word_score;
  logic [15:0] frames_seen;

  int checks = 0;
  int errors = 0;

  word_decision_if #(.NUM_CLASSES(8), .DATA_W(16)) prob_if ();

  word_decision #(
    .NUM_CLASSES(8), .DATA_W(16), .THRESH(256), .HOLD_FRAMES(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .prob(prob_if),
    .frame_done(frame_done), .frame_id(frame_id), .frame_score(frame_score),
    .word_valid(word_valid), .word_id(word_id), .word_score(word_score),
    .frames_seen(frames_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, $signed(observed), observed,
               $signed(expected), expected);
    end
  endtask

  function automatic logic [127:0] mk(input int a0, a1, a2, a3, a4, a5, a6, a7);
    logic [127:0] f;
    f[15:0]    = 16'(a0);
    f[31:16]   = 16'(a1);
    f[47:32]   = 16'(a2);
    f[63:48]   = 16'(a3);
    f[79:64]   = 16'(a4);
    f[95:80]   = 16'(a5);
    f[111:96]  = 16'(a6);
    f[127:112] = 16'(a7);
    return f;
  endfunction

  // Called at a negedge; returns at the negedge of the frame_done cycle (or after a timeout).
  task automatic applyStimulus(input logic [127:0] f, output int done_cycle, output int words,
                               output int ready_bad);
    int n;
    done_cycle = -1;
    words      = 0;
    ready_bad  = 0;
    n = 0;
    while (!prob_if.prob_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("ready_wait", 32'(prob_if.prob_ready), 32'd1);
    prob_if.prob_valid = 1'b1;
    prob_if.prob_flat  = f;
    @(posedge clk);
    #1;
    prob_if.prob_valid = 1'b0;
    for (int c = 1; c <= 12 && done_cycle < 0; c++) begin
      @(negedge clk);
      if (word_valid) words++;
      if (c <= 8 && prob_if.prob_ready) ready_bad++;
      if (frame_done) done_cycle = c;
    end
  endtask

  logic [127:0] f2, f4, f1, flow, ftie, fneg;
  int dc, wv, rb, wsum;

  initial begin
    f2   = mk(100, 200, 900, 50, 0, 0, 0, 0);
    f4   = mk(0, 0, 0, 0, 900, 0, 0, 0);
    f1   = mk(0, 900, 0, 0, 0, 0, 0, 0);
    flow = mk(255, 255, 255, 255, 255, 255, 255, 255);
    ftie = mk(0, 0, 0, 700, 0, 700, 0, 0);
    fneg = mk(-1000, -1000, -1000, -1000, -1000, -1000, -1000, -5);

    // Reset held with valid asserted
    rst_n = 1'b0;
    prob_if.prob_valid = 1'b1;
    prob_if.prob_flat  = f2;
    repeat (2) @(negedge clk);
    checkOutput("rst_ready", 32'(prob_if.prob_ready), 32'd0);
    checkOutput("rst_frame_done", 32'(frame_done), 32'd0);
    checkOutput("rst_frame_id", 32'(frame_id), 32'd0);
    checkOutput("rst_frame_score", 32'(frame_score), 32'd0);
    checkOutput("rst_word_valid", 32'(word_valid), 32'd0);
    checkOutput("rst_word_id", 32'(word_id), 32'd0);
    checkOutput("rst_word_score", 32'(word_score), 32'd0);
    checkOutput("rst_frames_seen", 32'(frames_seen), 32'd0);
    prob_if.prob_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_ready", 32'(prob_if.prob_ready), 32'd1);
    checkOutput("post_rst_frames_seen", 32'(frames_seen), 32'd0);

    // Single frame: timing and argmax
    applyStimulus(f2, dc, wv, rb);
    checkOutput("f1_done_cycle", 32'(dc), 32'd9);
    checkOutput("f1_ready_low", 32'(rb), 32'd0);
    checkOutput("f1_frame_id", 32'(frame_id), 32'd2);
    checkOutput("f1_frame_score", 32'(frame_score), 32'd900);
    checkOutput("f1_word", 32'(wv), 32'd0);
    checkOutput("f1_ready_again", 32'(prob_if.prob_ready), 32'd1);

    // Second and third identical frames back-to-back: word on the third
    applyStimulus(f2, dc, wv, rb);
    checkOutput("f2_word", 32'(wv), 32'd0);
    applyStimulus(f2, dc, wv, rb);
    checkOutput("f3_done_cycle", 32'(dc), 32'd9);
    checkOutput("f3_word", 32'(wv), 32'd1);
    checkOutput("f3_word_valid_now", 32'(word_valid), 32'd1);
    checkOutput("f3_word_id", 32'(word_id), 32'd2);
    checkOutput("f3_word_score", 32'(word_score), 32'd900);
    applyStimulus(f2, dc, wv, rb);
    checkOutput("f4_no_reemit", 32'(wv), 32'd0);
    checkOutput("f4_frames_seen", 32'(frames_seen), 32'd4);
    checkOutput("f4_word_id_held", 32'(word_id), 32'd2);

    // Tie keeps lower index; all-negative frame
    applyStimulus(ftie, dc, wv, rb);
    checkOutput("tie_frame_id", 32'(frame_id), 32'd3);
    checkOutput("tie_frame_score", 32'(frame_score), 32'd700);
    applyStimulus(fneg, dc, wv, rb);
    checkOutput("neg_frame_id", 32'(frame_id), 32'd7);
    checkOutput("neg_frame_score", 32'(frame_score), 32'hFFFF_FFFB);

    // 2,2,low,2 breaks the run
    wsum = 0;
    applyStimulus(f2, dc, wv, rb);   wsum += wv;
    applyStimulus(f2, dc, wv, rb);   wsum += wv;
    applyStimulus(flow, dc, wv, rb); wsum += wv;
    checkOutput("low_frame_score", 32'(frame_score), 32'd255);
    applyStimulus(f2, dc, wv, rb);   wsum += wv;
    checkOutput("broken_run_words", 32'(wsum), 32'd0);
    // 2,2,2 after that: exactly one pulse
    wsum = 0;
    repeat (3) begin
      applyStimulus(f2, dc, wv, rb); wsum += wv;
    end
    checkOutput("rerun_words", 32'(wsum), 32'd1);
    // 2,2,4,4,4: one pulse, class 4
    wsum = 0;
    applyStimulus(f2, dc, wv, rb); wsum += wv;
    applyStimulus(f2, dc, wv, rb); wsum += wv;
    repeat (3) begin
      applyStimulus(f4, dc, wv, rb); wsum += wv;
    end
    checkOutput("switch_words", 32'(wsum), 32'd1);
    checkOutput("switch_word_id", 32'(word_id), 32'd4);
    checkOutput("switch_word_score", 32'(word_score), 32'd900);
    checkOutput("frames_seen_18", 32'(frames_seen), 32'd18);

    // Reset during SCAN aborts the frame
    prob_if.prob_valid = 1'b1;
    prob_if.prob_flat  = f2;
    @(posedge clk);
    #1;
    prob_if.prob_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wsum = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (frame_done || word_valid) wsum++;
    end
    checkOutput("abort_no_pulse", 32'(wsum), 32'd0);
    checkOutput("abort_idle_ready", 32'(prob_if.prob_ready), 32'd1);
    checkOutput("abort_frames_seen", 32'(frames_seen), 32'd0);
    wsum = 0;
    repeat (3) begin
      applyStimulus(f1, dc, wv, rb); wsum += wv;
    end
    checkOutput("post_abort_words", 32'(wsum), 32'd1);
    checkOutput("post_abort_word_id", 32'(word_id), 32'd1);
    checkOutput("post_abort_frames_seen", 32'(frames_seen), 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
